// File: rtl/seq_bit_serializer_if.sv
// Word-in / bit-out handshake bundle for the parallel-to-serial front end.
// master drives words in; slave is the serializer.
interface seq_bit_serializer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             busy;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  ser_out,
        input  ser_valid,
        input  busy
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output ser_out,
        output ser_valid,
        output busy
    );
endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in, one bit per clk out.
// A single hold buffer behind the shifter gives gap-free back-to-back words.
module seq_bit_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    seq_bit_serializer_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] hold_reg;
    logic [CW-1:0]    bit_cnt;
    logic             hold_full;

    logic             accept;
    logic             last_bit;
    logic             head_bit;
    logic [WIDTH-1:0] shifted;

    // Ready comes from registered state only, never from din_valid.
    assign accept   = bus.din_valid && !hold_full;
    assign last_bit = (state == ST_SHIFT) && (bit_cnt == LAST);

    assign head_bit = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];
    assign shifted  = MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0}
                                : {1'b0, shift_reg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            hold_reg  <= '0;
            bit_cnt   <= '0;
            hold_full <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    if (accept) begin
                        shift_reg <= bus.din;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (last_bit) begin
                        bit_cnt <= '0;
                        // Hold drains first; ready is low then, so no accept collides.
                        if (hold_full) begin
                            shift_reg <= hold_reg;
                            hold_full <= 1'b0;
                        end else if (accept) begin
                            shift_reg <= bus.din;
                        end else begin
                            shift_reg <= shifted;
                            state     <= ST_IDLE;
                        end
                    end else begin
                        shift_reg <= shifted;
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (accept) begin
                            hold_reg  <= bus.din;
                            hold_full <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.din_ready = !hold_full;
    assign bus.ser_valid = (state == ST_SHIFT);
    assign bus.ser_out   = (state == ST_SHIFT) ? head_bit : IDLE_BIT;
    assign bus.busy      = (state == ST_SHIFT) || hold_full;
endmodule
